// File: rtl/count_sequencer.sv
// count_sequencer: prescaled modulo-N LED counter with start/pause/abort and auto-stop after N wraps.
module count_sequencer #(
    parameter int CNT_W   = 3,
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_mod,
    input  logic [3:0]       cfg_cycles,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_pre, r_div, w_div_m1;
    logic [CNT_W-1:0] r_count, r_mod, w_mod_m1, w_cnt_nxt;
    logic [3:0]       r_wrap, r_cyc, w_wrap_nxt;
    logic             r_tick, w_run, w_tick, w_wrap, w_fin, w_clear;

    // div 0 behaves as 1; mod 0 wraps naturally to the full 2**CNT_W range
    assign w_div_m1   = (r_div == '0) ? '0 : r_div - DIV_W'(1);
    assign w_mod_m1   = r_mod - CNT_W'(1);
    assign w_run      = (r_state == S_RUN) && !stop;
    assign w_tick     = w_run && (r_pre == w_div_m1);
    assign w_cnt_nxt  = (r_count == w_mod_m1) ? '0 : r_count + CNT_W'(1);
    assign w_wrap     = w_tick && (w_cnt_nxt == '0);
    assign w_wrap_nxt = r_wrap + 4'd1;
    assign w_fin      = w_wrap && (r_cyc != 4'd0) && (w_wrap_nxt == r_cyc);
    assign w_clear    = ((r_state == S_IDLE) && start && !stop) || ((r_state == S_PAUSE) && stop);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = (start && !stop) ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = stop ? S_PAUSE : (w_fin ? S_DONE : S_RUN);
            S_PAUSE: w_state_nxt = stop ? S_IDLE : (start ? S_RUN : S_PAUSE);
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre   <= '0;
            r_count <= '0;
            r_wrap  <= '0;
            r_tick  <= 1'b0;
            r_div   <= DIV_W'(DEF_DIV);
            r_mod   <= '0;
            r_cyc   <= '0;
        end else begin
            r_tick <= w_tick;
            if ((r_state == S_IDLE) && cfg_valid) begin
                r_div <= cfg_div;
                r_mod <= cfg_mod;
                r_cyc <= cfg_cycles;
            end
            if (w_clear) begin
                r_pre   <= '0;
                r_count <= '0;
                r_wrap  <= '0;
            end else if (w_run) begin
                r_pre <= w_tick ? '0 : r_pre + DIV_W'(1);
                if (w_tick) r_count <= w_cnt_nxt;
                if (w_wrap) r_wrap <= w_wrap_nxt;
            end
        end
    end

    assign tick      = r_tick;
    assign count     = r_count;
    assign busy      = (r_state == S_RUN) || (r_state == S_PAUSE);
    assign done      = (r_state == S_DONE);
    assign cfg_ready = (r_state == S_IDLE);
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: scoreboard bench; expected ticks/counts are queued at start and checked as the DUT ticks.
module tb_count_sequencer;
    logic        clk, reset, start, stop, cfg_valid, cfg_ready, tick, busy, done;
    logic [15:0] cfg_div;
    logic [2:0]  cfg_mod, count;
    logic [3:0]  cfg_cycles;

    typedef struct {int t; int c;} ev_t;
    ev_t q[$];
    int  n_tests = 0, n_fail = 0, edge_n = 0, exp_done = -1, t0;
    bit  mon_en = 1;

    count_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_div(cfg_div),
        .cfg_mod(cfg_mod), .cfg_cycles(cfg_cycles), .tick(tick),
        .count(count), .busy(busy), .done(done)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Independent tick schedule: one tick every max(div,1) edges, count modulo mod (0 -> 8).
    task push_run(input int div, input int mod, input int ncyc, input int ts, input int max_ticks);
        int d, m, c, w;
        d = (div == 0) ? 1 : div;
        m = (mod == 0) ? 8 : mod;
        c = 0;
        w = 0;
        exp_done = -1;
        for (int i = 1; i <= max_ticks; i++) begin
            c = (c + 1) % m;
            q.push_back('{ts + i * d, c});
            if (c == 0) w++;
            if (ncyc != 0 && w == ncyc) begin
                exp_done = ts + i * d;
                break;
            end
        end
    endtask

    task go(input int div, input int mod, input int ncyc, input int max_ticks);
        cfg_valid = 1; cfg_div = 16'(div); cfg_mod = 3'(mod); cfg_cycles = 4'(ncyc); start = 1;
        @(negedge clk);
        cfg_valid = 0; start = 0;
        t0 = edge_n;
        push_run(div, mod, ncyc, t0, max_ticks);
    endtask

    task wait_to(input int t);
        while (edge_n < t) @(negedge clk);
    endtask

    always @(posedge clk) begin
        ev_t e;
        #1;
        if (mon_en) begin
            if (tick) begin
                if (q.size() == 0) chk("extra_tick", edge_n, -1);
                else begin
                    e = q.pop_front();
                    chk("tick_t", edge_n, e.t);
                    chk("tick_cnt", int'(count), e.c);
                end
            end else if (q.size() > 0 && q[0].t <= edge_n) begin
                chk("tick_missing", 0, 1);
                void'(q.pop_front());
            end
            if (done || edge_n == exp_done) chk("done_t", done ? edge_n : -1, exp_done);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 0; start = 0; stop = 0; cfg_valid = 0; cfg_div = 0; cfg_mod = 0; cfg_cycles = 0;
        repeat (2) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        reset = 1;
        @(negedge clk);

        // div=3 mod=5 cycles=2: done 30 edges after start
        go(3, 5, 2, 100);
        chk("t1_done_at", exp_done - t0, 30);
        chk("t1_busy", int'(busy), 1);
        wait_to(exp_done);
        @(negedge clk);
        chk("t1_idle_busy", int'(busy), 0);
        chk("t1_idle_ready", int'(cfg_ready), 1);
        chk("t1_q_empty", q.size(), 0);

        // div=1 mod=0 cycles=1: 1..7,0 on consecutive edges
        go(1, 0, 1, 100);
        wait_to(exp_done);
        @(negedge clk);
        chk("t2_busy", int'(busy), 0);
        chk("t2_q_empty", q.size(), 0);

        // div=0 (as 1), mod=1 (stuck at 0), 3 wraps
        go(0, 1, 3, 100);
        wait_to(exp_done);
        @(negedge clk);
        chk("t3_busy", int'(busy), 0);
        chk("t3_q_empty", q.size(), 0);

        // pause after 2 ticks, hold 10, cfg offered while busy must wait
        go(4, 0, 0, 2);
        wait_to(t0 + 8);
        stop = 1;
        @(negedge clk);
        stop = 0;
        cfg_valid = 1; cfg_div = 2; cfg_mod = 3; cfg_cycles = 1;
        for (int i = 0; i < 10; i++) begin
            chk("p_count", int'(count), 2);
            chk("p_busy", int'(busy), 1);
            chk("p_ready", int'(cfg_ready), 0);
            @(negedge clk);
        end
        start = 1;
        @(negedge clk);
        start = 0;
        push_run(4, 0, 0, edge_n, 0);
        q.push_back('{edge_n + 4, 3});
        wait_to(edge_n + 4);
        chk("p_q_empty", q.size(), 0);
        stop = 1;
        @(negedge clk);
        chk("ab_pause_cnt", int'(count), 3);
        chk("ab_pause_busy", int'(busy), 1);
        @(negedge clk);
        stop = 0;
        chk("ab_busy", int'(busy), 0);
        chk("ab_count", int'(count), 0);
        chk("ab_ready", int'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        t0 = edge_n;
        push_run(2, 3, 1, t0, 100);
        wait_to(exp_done);
        @(negedge clk);
        chk("hs_busy", int'(busy), 0);
        chk("hs_q_empty", q.size(), 0);

        // start+stop together in PAUSE -> IDLE; also start+stop in IDLE stays idle
        go(2, 0, 0, 1);
        wait_to(t0 + 2);
        stop = 1;
        @(negedge clk);
        chk("ss_paused", int'(busy), 1);
        start = 1;
        @(negedge clk);
        chk("ss_busy", int'(busy), 0);
        chk("ss_count", int'(count), 0);
        @(negedge clk);
        start = 0; stop = 0;
        chk("ss_idle_busy", int'(busy), 0);

        // async reset mid-run, then defaults (div 4, full range) are back
        mon_en = 0;
        go(1, 0, 0, 0);
        repeat (3) @(negedge clk);
        #2 reset = 0;
        #1;
        chk("ar_count", int'(count), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_tick", int'(tick), 0);
        chk("ar_ready", int'(cfg_ready), 1);
        #1 reset = 1;
        @(negedge clk);
        q.delete();
        mon_en = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        t0 = edge_n;
        push_run(4, 0, 0, t0, 3);
        wait_to(t0 + 12);
        chk("def_q_empty", q.size(), 0);
        stop = 1;
        repeat (2) @(negedge clk);
        stop = 0;
        chk("def_abort_busy", int'(busy), 0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
